// File: rtl/sobel_pkg.sv
// Shared definitions for the 3x3 sliding-window front end of the Sobel pipeline.
// Holds the default image geometry, the pixel width and the pixel type.
package sobel_pkg;

    localparam int DW        = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef logic [DW-1:0] pixel_t;

endpackage

// File: rtl/line_ram.sv
// One-line pixel store: single address, combinational read, write on the clock edge,
// so a read and a write to the same column in one cycle returns the old pixel.
module line_ram #(
    parameter int DEPTH = sobel_pkg::IMG_W_DEF,
    parameter int DW    = sobel_pkg::DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Line contents need no reset: every column is rewritten before it feeds a window.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/line_window.sv
// Raster-to-3x3 window generator: two line stores plus a shifting 3x3 register window,
// producing one window per accepted pixel once two full lines and two columns are available.
module line_window
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = sobel_pkg::DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_pixel,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7,
    output logic [DW-1:0] out8,
    output logic [DW-1:0] out9,
    output logic          out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] win_q [3][3];
    logic [DW-1:0] win_d [3][3];

    logic          accept_s;
    logic          win_pos_s;
    logic          frame_end_s;
    logic [DW-1:0] row1_rd_s;
    logic [DW-1:0] row2_rd_s;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept_s    = in_valid && in_ready;
    assign win_pos_s   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign frame_end_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Row-1 store takes the incoming pixel; its previous content cascades into the row-2 store.
    line_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_row1 (
        .clock   (clock),
        .we      (accept_s),
        .addr    (col_q),
        .wr_data (in_pixel),
        .rd_data (row1_rd_s)
    );

    line_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_row2 (
        .clock   (clock),
        .we      (accept_s),
        .addr    (col_q),
        .wr_data (row1_rd_s),
        .rd_data (row2_rd_s)
    );

    // Raster position: advances once per accepted pixel, wrapping at line and frame ends.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window shifts left on accept; the new right column is {row-2, row-1, current}.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = row2_rd_s;
            win_d[1][2] = row1_rd_s;
            win_d[2][2] = in_pixel;
        end else begin
            win_d = win_q;
        end
    end

    // Output handshake: load on accept, hold while stalled, otherwise retire.
    always_comb begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (accept_s) begin
            out_valid_d = win_pos_s;
            out_last_d  = frame_end_s;
        end else if (out_valid_q && !out_ready) begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            win_q       <= '{default: '0};
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out1 = win_q[0][0];
    assign out2 = win_q[0][1];
    assign out3 = win_q[0][2];
    assign out4 = win_q[1][0];
    assign out5 = win_q[1][1];
    assign out6 = win_q[1][2];
    assign out7 = win_q[2][0];
    assign out8 = win_q[2][1];
    assign out9 = win_q[2][2];

endmodule

// File: tb/tb_line_window.sv
// Directed bench for line_window: a 4x4 instance for the streaming, stall, back-to-back
// and reset scenarios, and a 5x3 instance driven with random gaps and random back-pressure.
module tb_line_window;
    import sobel_pkg::*;

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } cap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [7:0] a_in_pixel, a_out1, a_out2, a_out3, a_out4, a_out5, a_out6, a_out7, a_out8, a_out9;
    logic       b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0] b_in_pixel, b_out1, b_out2, b_out3, b_out4, b_out5, b_out6, b_out7, b_out8, b_out9;
    logic [71:0] win_a, win_b, b_held;
    logic        b_stall_prev;
    cap_t        qa[$];
    cap_t        qb[$];
    pixel_t      b_img [15];

    assign win_a = {a_out1, a_out2, a_out3, a_out4, a_out5, a_out6, a_out7, a_out8, a_out9};
    assign win_b = {b_out1, b_out2, b_out3, b_out4, b_out5, b_out6, b_out7, b_out8, b_out9};

    line_window #(.IMG_W(4), .IMG_H(4), .DW(8)) u_a (
        .clock(clk), .reset(a_reset), .in_valid(a_in_valid), .in_pixel(a_in_pixel),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out1(a_out1), .out2(a_out2), .out3(a_out3), .out4(a_out4), .out5(a_out5),
        .out6(a_out6), .out7(a_out7), .out8(a_out8), .out9(a_out9), .out_last(a_out_last)
    );

    line_window #(.IMG_W(5), .IMG_H(3), .DW(8)) u_b (
        .clock(clk), .reset(b_reset), .in_valid(b_in_valid), .in_pixel(b_in_pixel),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out1(b_out1), .out2(b_out2), .out3(b_out3), .out4(b_out4), .out5(b_out5),
        .out6(b_out6), .out7(b_out7), .out8(b_out8), .out9(b_out9), .out_last(b_out_last)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 4x4 test image: frame 0 is 16*r+c, frame 1 adds 100.
    function automatic logic [7:0] pix_val(input int f, input int r, input int c);
        return 8'(((f == 1) ? 100 : 0) + 16 * r + c);
    endfunction

    function automatic logic [7:0] pix_a(input int idx);
        return pix_val(idx / 16, (idx % 16) / 4, idx % 4);
    endfunction

    function automatic logic [71:0] exp_a(input int f, input int wi);
        logic [71:0] w;
        int r;
        int c;
        w = '0;
        r = 2 + wi / 2;
        c = 2 + wi % 2;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], pix_val(f, r - 2 + i, c - 2 + j)};
        return w;
    endfunction

    function automatic logic [71:0] exp_b(input int k);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], b_img[i * 5 + k + j]};
        return w;
    endfunction

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) qa.push_back(cap_t'{win: win_a, last: a_out_last});
    end

    always @(negedge clk) begin
        if (b_stall_prev) begin
            check("b_hold_valid", 72'(b_out_valid), 72'(1));
            check("b_hold_win", win_b, b_held);
        end
        if (b_out_valid && !b_out_ready) begin
            check("b_stall_in_ready", 72'(b_in_ready), 72'(0));
            b_stall_prev <= 1'b1;
            b_held       <= win_b;
        end else begin
            b_stall_prev <= 1'b0;
        end
        if (b_out_valid && b_out_ready) qb.push_back(cap_t'{win: win_b, last: b_out_last});
    end

    task automatic run_a(input int npix, input bit stall);
        int idx;
        int cyc;
        int stall_left;
        bit stall_done;
        logic rdy;
        logic [71:0] held;
        idx = 0; cyc = 0; stall_left = 0; stall_done = 1'b0; held = '0;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_pixel  = pix_a(0);
        while (idx < npix && cyc < 400) begin
            @(negedge clk);
            rdy = a_in_ready;
            @(posedge clk);
            if (a_in_valid && rdy) idx++;
            #1;
            cyc++;
            if (stall_left > 0) begin
                check("stall_valid", 72'(a_out_valid), 72'(1));
                check("stall_win", win_a, held);
                check("stall_in_ready", 72'(a_in_ready), 72'(0));
                stall_left--;
                if (stall_left == 0) a_out_ready = 1'b1;
            end else if (stall && !stall_done && a_out_valid) begin
                a_out_ready = 1'b0;
                held        = win_a;
                stall_left  = 3;
                stall_done  = 1'b1;
            end
            a_in_valid = (idx < npix);
            a_in_pixel = pix_a(idx);
        end
        check("a_timeout", 72'(cyc < 400), 72'(1));
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_a(input int nframes);
        check("a_count", 72'(qa.size()), 72'(4 * nframes));
        for (int k = 0; k < 4 * nframes; k++) begin
            if (k < qa.size()) begin
                check("a_win", qa[k].win, exp_a(k / 4, k % 4));
                check("a_last", 72'(qa[k].last), 72'(k % 4 == 3));
            end
        end
    endtask

    task automatic run_b();
        int idx;
        int cyc;
        logic rdy;
        idx = 0; cyc = 0;
        b_in_valid  = 1'($urandom_range(0, 1));
        b_in_pixel  = b_img[0];
        b_out_ready = 1'($urandom_range(0, 1));
        while (idx < 15 && cyc < 1000) begin
            @(negedge clk);
            rdy = b_in_ready;
            @(posedge clk);
            if (b_in_valid && rdy) idx++;
            #1;
            cyc++;
            b_in_valid  = (idx < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_in_pixel  = b_img[(idx < 15) ? idx : 0];
            b_out_ready = 1'($urandom_range(0, 1));
        end
        check("b_timeout", 72'(cyc < 1000), 72'(1));
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        b_stall_prev = 1'b0;
        b_held       = '0;
        a_reset = 1'b1; a_in_valid = 1'b0; a_in_pixel = 8'd0; a_out_ready = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_pixel = 8'd0; b_out_ready = 1'b0;
        for (int i = 0; i < 15; i++) b_img[i] = 8'($urandom_range(0, 255));
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 72'(a_out_valid), 72'(0));
        check("rst_out_last", 72'(a_out_last), 72'(0));
        check("rst_window", win_a, 72'(0));
        check("rst_in_ready", 72'(a_in_ready), 72'(1));
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Single frame, no back-pressure.
        qa.delete();
        run_a(16, 1'b0);
        compare_a(1);
        if (qa.size() == 4) begin
            check("t1_first", qa[0].win, {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34});
            check("t1_out9_last", 72'(qa[3].win[7:0]), 72'(51));
        end

        // Same frame with a three-cycle stall on the first window.
        qa.delete();
        run_a(16, 1'b1);
        compare_a(1);

        // Two frames back to back.
        qa.delete();
        run_a(32, 1'b0);
        compare_a(2);
        if (qa.size() == 8) begin
            check("t3_w5_out1", 72'(qa[4].win[71:64]), 72'(100));
            check("t3_w5_out9", 72'(qa[4].win[7:0]), 72'(134));
        end

        // Abort mid-frame with reset, then a clean frame.
        qa.delete();
        run_a(9, 1'b0);
        a_reset    = 1'b1;
        a_in_valid = 1'b1;
        a_in_pixel = 8'hff;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t4_rst_valid", 72'(a_out_valid), 72'(0));
        end
        a_reset    = 1'b0;
        a_in_valid = 1'b0;
        check("t4_pre_windows", 72'(qa.size()), 72'(0));
        qa.delete();
        run_a(16, 1'b0);
        compare_a(1);

        // 5x3 frame with random gaps and random back-pressure.
        qb.delete();
        run_b();
        check("b_count", 72'(qb.size()), 72'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < qb.size()) begin
                check("b_win", qb[k].win, exp_b(k));
                check("b_last", 72'(qb[k].last), 72'(k == 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_window.md
LINE_WINDOW -- requirements
Module: line_window

Interface
REQ-001 Parameter: IMG_W, 640, pixels per line (>=3).
REQ-002 Parameter: IMG_H, 480, lines per frame (>=3).
REQ-003 Parameter: DW, 8, pixel width in bits.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port: clock  in  1  rising-edge clock for all state.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: in_valid  in  1  in_pixel valid.
REQ-008 Port: in_pixel  in  DW  raster pixel, row-major, first pixel of frame first.
REQ-009 Port: in_ready  out  1  block accepts in_pixel this cycle.
REQ-010 Port: out_valid  out  1  window outputs valid.
REQ-011 Port: out_ready  in  1  downstream convolution stage accepts the window.
REQ-012 Port: out1..out9  out  DW each  3x3 window, row-major: out1 top-left, out5 centre, out9 bottom-right.
REQ-013 Port: out_last  out  1  marks the final window of a frame.

Function
REQ-014 A pixel SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance once per accepted pixel, wrapping col to 0 with row+1, and wrapping both to 0 after (IMG_H-1, IMG_W-1).
REQ-017 Two line memories of IMG_W x DW SHALL hold rows row-1 and row-2; on accept at column col they SHALL be read at col and updated at col (read-before-write), with row-1 data moving into the row-2 memory.
REQ-018 A 3x3 register window SHALL shift left one column per accept, loading the new right column {row-2, row-1, row} at col.
REQ-019 When the pixel accepted at (row, col) has row>=2 and col>=2, out_valid SHALL be 1 in the next cycle.
REQ-020 In that cycle, out1..out9 SHALL be pixels (row-2, col-2 .. col), (row-1, col-2 .. col), (row, col-2 .. col) in row-major order.
REQ-021 Accepts with row<2 or col<2 SHALL update state but produce no window; no window SHALL mix pixels from different frames or wrap across a line end.
REQ-022 Each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-023 out_last SHALL be 1 exactly with the window produced by pixel (IMG_H-1, IMG_W-1).
REQ-024 While out_valid=1 and out_ready=0, out_valid, out1..out9 and out_last SHALL hold stable and no pixel SHALL be accepted.
REQ-025 When out_valid=1 and out_ready=1, a new window MAY load in the same cycle; otherwise out_valid SHALL drop to 0.
REQ-026 Latency SHALL be one cycle from an accepted pixel to its window; sustained throughput SHALL be one pixel per cycle when out_ready=1.
REQ-027 Back-to-back frames SHALL need no idle cycles; the first pixel after pixel (IMG_H-1, IMG_W-1) SHALL be (0, 0) of the next frame.

Reset
REQ-028 Reset SHALL set row=0, col=0, out_valid=0, out_last=0 and out1..out9=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel SHALL be (0, 0), and no window SHALL use pre-reset line data.
REQ-030 Line memory contents SHALL NOT require reset.

Structure
REQ-031 Shared package sobel_pkg SHALL hold DW, the default IMG_W and IMG_H, and the pixel type.
REQ-032 Line storage SHALL be one sub-module line_ram (IMG_W x DW, one address, read-before-write), instantiated twice.

Verification
REQ-033 IMG_W=4, IMG_H=4, pixel=16*r+c, out_ready=1 -> 4 windows; first is out1..out9 = 0,1,2,16,17,18,32,33,34; out_last only on the 4th, whose out9=51.
REQ-034 Same image, out_ready held 0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0, no pixel lost, same 4 windows.
REQ-035 Two back-to-back 4x4 frames, second frame pixel=100+16*r+c -> 8 windows; the 5th window's out1=100 and out9=134.
REQ-036 Reset asserted after 9 pixels, then a full 4x4 frame -> out_valid=0 during reset; exactly 4 windows after, identical to REQ-033.
REQ-037 Random in_valid gaps with a 50% random out_ready on a 5x3 frame -> 3 windows matching a software 3x3 model, one out_last.
